// File: rtl/timer_regs_pkg.sv
// Shared definitions for the interval-timer driver.
//   - Register indices of the 16-bit interval timer slave.
//   - Bit positions inside the timer control register.
//   - Driver FSM state encoding.
//   - Helper that assembles a control-register word.
package timer_regs_pkg;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int ITO   = 0;
   localparam int CONT  = 1;
   localparam int START = 2;
   localparam int STOP  = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CTRL,
      ST_RUN,
      ST_CLR_ST,
      ST_IRQ_GAP,
      ST_STOP_WR,
      ST_SNAP_WR,
      ST_SNAP_RL,
      ST_SNAP_RH,
      ST_SNAP_CAP
   } drv_state_t;

   function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
      logic [15:0] w;
      w        = '0;
      w[STOP]  = stop;
      w[START] = start;
      w[CONT]  = cont;
      w[ITO]   = ito;
      return w;
   endfunction

endpackage

// File: rtl/avalon_mm_tx_reg.sv
// Registered Avalon-MM master beat generator.
// A request presented on one cycle appears on the bus for exactly the next
// cycle: a write beat (chipselect=1, write_n=0) or a read beat
// (chipselect=1, write_n=1). With no request the bus returns to idle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   wr_req, rd_req      beat request for the next cycle (write has priority)
//   addr, wdata         register index and write data of the request
//   m_address, m_chipselect, m_write_n, m_writedata   registered bus outputs
module avalon_mm_tx_reg (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_req,
   input  logic        rd_req,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [15:0] m_writedata
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_address    <= '0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
      end else begin
         m_chipselect <= wr_req | rd_req;
         m_write_n    <= ~wr_req;
         m_address    <= (wr_req | rd_req) ? addr : 3'd0;
         m_writedata  <= wr_req ? wdata : 16'd0;
      end
   end

endmodule

// File: rtl/timer_avalon_driver.sv
// Avalon-MM master that programs and services the interval timer slave.
// Game logic issues start/stop/snapshot pulses; this block turns them into
// register write/read sequences, clears timeouts on irq and counts ticks.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_start/period/continuous  program period and start (IDLE only)
//   cmd_stop                     stop the timer (RUN only)
//   snap_req                     latch and read the 32-bit counter
//   busy, running                status
//   tick_pulse, tick_count       serviced timeouts
//   snap_valid, snap_value       snapshot result
//   m_*                          Avalon-MM master towards the timer
//   timer_irq                    timer interrupt (level)
module timer_avalon_driver
   import timer_regs_pkg::*;
#(
   parameter int          TICK_W     = 16,
   parameter logic [31:0] DEF_PERIOD = 32'd49999
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_start,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_continuous,
   input  logic              cmd_stop,
   input  logic              snap_req,
   output logic              busy,
   output logic              running,
   output logic              tick_pulse,
   output logic [TICK_W-1:0] tick_count,
   output logic              snap_valid,
   output logic [31:0]       snap_value,
   output logic [2:0]        m_address,
   output logic              m_chipselect,
   output logic              m_write_n,
   output logic [15:0]       m_writedata,
   input  logic [15:0]       m_readdata,
   input  logic              timer_irq
);

   drv_state_t  state_reg, state_next;
   logic [31:0] period_reg;
   logic        cont_reg;
   logic [31:0] start_period;

   logic        beat_wr, beat_rd;
   logic [2:0]  beat_addr;
   logic [15:0] beat_data;

   assign start_period = (cmd_period == 32'd0) ? DEF_PERIOD : cmd_period;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (cmd_start)     state_next = ST_WR_PL;
                      else if (snap_req) state_next = ST_SNAP_WR;
         ST_WR_PL:    state_next = ST_WR_PH;
         ST_WR_PH:    state_next = ST_WR_CTRL;
         ST_WR_CTRL:  state_next = ST_RUN;
         ST_RUN:      if (timer_irq)     state_next = ST_CLR_ST;
                      else if (cmd_stop) state_next = ST_STOP_WR;
                      else if (snap_req) state_next = ST_SNAP_WR;
         ST_CLR_ST:   state_next = ST_IRQ_GAP;
         ST_IRQ_GAP:  state_next = cont_reg ? ST_RUN : ST_IDLE;
         ST_STOP_WR:  state_next = ST_IDLE;
         ST_SNAP_WR:  state_next = ST_SNAP_RL;
         ST_SNAP_RL:  state_next = ST_SNAP_RH;
         ST_SNAP_RH:  state_next = ST_SNAP_CAP;
         ST_SNAP_CAP: state_next = running ? ST_RUN : ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // The beat is requested for the state being entered, so the registered
   // bus outputs line up with state_reg. This keeps the read latency simple:
   // data for the read issued in state S arrives while in the state after S.
   always_comb begin
      beat_wr   = 1'b0;
      beat_rd   = 1'b0;
      beat_addr = ADDR_STATUS;
      beat_data = 16'd0;
      case (state_next)
         ST_WR_PL: begin
            // Only entered from IDLE, where the period is not yet latched.
            beat_wr   = 1'b1;
            beat_addr = ADDR_PERIODL;
            beat_data = start_period[15:0];
         end
         ST_WR_PH: begin
            beat_wr   = 1'b1;
            beat_addr = ADDR_PERIODH;
            beat_data = period_reg[31:16];
         end
         ST_WR_CTRL: begin
            beat_wr   = 1'b1;
            beat_addr = ADDR_CONTROL;
            beat_data = ctrl_word(1'b0, 1'b1, cont_reg, 1'b1);
         end
         ST_CLR_ST: begin
            beat_wr   = 1'b1;
            beat_addr = ADDR_STATUS;
         end
         ST_STOP_WR: begin
            beat_wr   = 1'b1;
            beat_addr = ADDR_CONTROL;
            beat_data = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
         end
         ST_SNAP_WR: begin
            beat_wr   = 1'b1;
            beat_addr = ADDR_SNAPL;
         end
         ST_SNAP_RL: begin
            beat_rd   = 1'b1;
            beat_addr = ADDR_SNAPL;
         end
         ST_SNAP_RH: begin
            beat_rd   = 1'b1;
            beat_addr = ADDR_SNAPH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ST_IDLE;
         period_reg <= '0;
         cont_reg   <= 1'b0;
         busy       <= 1'b0;
         running    <= 1'b0;
         tick_pulse <= 1'b0;
         tick_count <= '0;
         snap_valid <= 1'b0;
         snap_value <= '0;
      end else begin
         state_reg <= state_next;
         busy      <= (state_next != ST_IDLE);

         if (state_reg == ST_IDLE && cmd_start) begin
            period_reg <= start_period;
            cont_reg   <= cmd_continuous;
         end

         if (state_next == ST_WR_CTRL)
            running <= 1'b1;
         else if (state_next == ST_IDLE)
            running <= 1'b0;

         // Tick is flagged in the same cycle as the status-clear write.
         tick_pulse <= (state_next == ST_CLR_ST);
         if (state_reg == ST_IDLE && cmd_start)
            tick_count <= '0;
         else if (state_next == ST_CLR_ST)
            tick_count <= tick_count + 1'b1;

         if (state_reg == ST_SNAP_RH)
            snap_value[15:0] <= m_readdata;
         if (state_reg == ST_SNAP_CAP)
            snap_value[31:16] <= m_readdata;
         // Pulses once both halves are in snap_value.
         snap_valid <= (state_reg == ST_SNAP_CAP);
      end
   end

   avalon_mm_tx_reg u_tx (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_req       (beat_wr),
      .rd_req       (beat_rd),
      .addr         (beat_addr),
      .wdata        (beat_data),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata)
   );

endmodule

// File: doc/timer_avalon_driver.md
Name: timer_avalon_driver

Overview:
- Avalon-MM master that programs and services the team's 16-bit-register interval timer slave (6 registers: status, control, period_l, period_h, snap_l, snap_h).
- Turns a simple command interface from game logic into the timer's register write/read sequences, services its irq and keeps a tick count.
- Supports 32-bit snapshot readback and stop. Sits between game-control FSMs and the timer, so hardware can use the timer without the Nios.

Parameters:
- TICK_W, 16, width of tick_count; wraps modulo 2^TICK_W.
- DEF_PERIOD, 32'd49999, period loaded when cmd_period is all-zero at cmd_start.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- cmd_start  in  1  pulse: program period and start timer (accepted in IDLE only)
- cmd_period  in  32  load value; timer counts load+1 clocks per tick
- cmd_continuous  in  1  1 = periodic, 0 = one-shot; sampled with cmd_start
- cmd_stop  in  1  pulse: stop timer (accepted in RUN only)
- snap_req  in  1  pulse: capture and read counter (accepted in IDLE or RUN)
- busy  out  1  high in every state except IDLE
- running  out  1  high from WR_CTRL issue until stop or one-shot completion
- tick_pulse  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since last cmd_start
- snap_valid  out  1  one-cycle pulse, snap_value updated
- snap_value  out  32  last snapshot
- m_address  out  3  timer register index
- m_chipselect  out  1  slave select
- m_write_n  out  1  active-low write
- m_writedata  out  16  write data
- m_readdata  in  16  slave readdata; registered, valid 1 cycle after address
- timer_irq  in  1  timer interrupt, level

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE.
  - busy, running, tick_pulse and snap_valid = 0.
  - tick_count = 0 and snap_value = 0.
  - m_chipselect = 0, m_write_n = 1, m_address = 0 and m_writedata = 0.
- Bus outputs are registered. A write occupies exactly one cycle with m_chipselect=1 and m_write_n=0. There is no waitrequest.
- A read drives m_address with m_write_n=1. m_readdata is captured on the following cycle (fixed latency 1).
- States and transitions:
  - IDLE: cmd_start goes to WR_PL. Otherwise snap_req goes to SNAP_WR. cmd_stop is ignored.
  - WR_PL: write addr 2 = period[15:0], go to WR_PH.
  - WR_PH: write addr 3 = period[31:16], go to WR_CTRL. Period writes must precede the control write, because a period write force-reloads and stops the timer.
  - WR_CTRL: write addr 1 = {STOP=0, START=1, CONT=cmd_continuous, ITO=1}, i.e. 0x7 or 0x5. Set running, go to RUN.
  - RUN: bus idle (chipselect=0). Priority is timer_irq, then cmd_stop, then snap_req.
    - timer_irq goes to CLR_ST.
    - cmd_stop goes to STOP_WR.
    - snap_req goes to SNAP_WR.
  - CLR_ST: write addr 0 = 0, which clears the timeout, then go to IRQ_GAP. Pulse tick_pulse and increment tick_count (wrap).
  - IRQ_GAP: one idle cycle so the deasserted irq is visible. If one-shot, clear running and go to IDLE. Otherwise go to RUN.
  - STOP_WR: write addr 1 = 0x8, clear running, go to IDLE.
  - SNAP_WR: write addr 4 = 0, which latches the counter, then go to SNAP_RL.
  - SNAP_RL: read addr 4, go to SNAP_RH.
  - SNAP_RH: read addr 5 and capture m_readdata into snap_value[15:0], go to SNAP_CAP.
  - SNAP_CAP: capture m_readdata into snap_value[31:16], pulse snap_valid. Return to RUN if running, else IDLE.
- Period and tick handling:
  - cmd_period == 0 loads DEF_PERIOD.
  - cmd_period and cmd_continuous are latched at cmd_start acceptance.
  - tick_count is cleared at cmd_start acceptance.
- Commands that are not accepted are dropped, not queued:
  - cmd_start while busy.
  - snap_req outside IDLE/RUN.
  - cmd_stop outside RUN.
- Simultaneous events:
  - cmd_start and snap_req together in IDLE: start wins, snap is dropped.
  - irq during a snapshot sequence: serviced on the next return to RUN.
  - cmd_stop in the same cycle as irq in RUN: irq is serviced first and the stop is dropped. The caller must reissue it.
- Reset mid-sequence aborts immediately; bus outputs return to idle values.

Decomposition:
- Shared package timer_regs_pkg:
  - Register address constants ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIODL=2, ADDR_PERIODH=3, ADDR_SNAPL=4, ADDR_SNAPH=5.
  - Control bit indices ITO=0, CONT=1, START=2, STOP=3.
  - State enum for the driver FSM.
- One sub-module is natural: avalon_mm_tx_reg, which registers the bus outputs and issues single-cycle write/read beats. The FSM stays in the top module.

Test Plan:
- Reset: hold reset_n low -> all outputs at reset values; after release, m_chipselect stays 0 for 10 cycles with no commands.
- Continuous start: cmd_start with period=9, cont=1, against the timer model -> writes (2,0x0009), (3,0x0000), (1,0x0007) on consecutive cycles; tick_pulse every 10 clocks plus service overhead; tick_count=5 after 5 irqs; each irq cleared by write (0,0).
- One-shot: period=4, cont=0 -> control write 0x0005; exactly one tick_pulse; busy=0 and running=0 two cycles after CLR_ST; no further irq.
- Snapshot: period=0x0001_0000, snap_req in RUN -> write (4,0), reads of addr 4 then 5; snap_value equals the model counter at the SNAP_WR cycle; snap_valid pulses once.
- Stop/priority: cmd_stop coincident with irq -> clear write first, no stop write; reissued cmd_stop -> write (1,0x0008), running=0, busy=0.
- Default/ignored: cmd_start with period=0 -> period writes 0xC34F / 0x0000; second cmd_start while busy -> no extra bus writes.
